// File: rtl/ascii_word_packer_v_pkg.sv
// ascii_word_packer_v_pkg
//   Shared definitions for the ASCII word packer: default geometry, FSM
//   state encoding and the ASCII constants used by the optional case folder.
//   (Plays the role of the shop_defs.vh header for this block.)
package ascii_word_packer_v_pkg;

  // Default geometry: three 8-bit characters per word.
  localparam int CHARS_DEF  = 3;
  localparam int CHAR_W_DEF = 8;

  // Packer FSM state. ST_ACC gathers characters. ST_PEND holds a completed
  // word in the assembly register while the output slot is still occupied.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_PEND = 1'b1
  } packer_state_e;

  // ASCII constants for lower-to-upper case folding.
  localparam logic [7:0] ASCII_LC_A     = 8'h61;  // 'a'
  localparam logic [7:0] ASCII_LC_Z     = 8'h7A;  // 'z'
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;  // 'a' - 'A'

  // True for the lower-case letters 'a'..'z'.
  function automatic logic is_lower(input logic [7:0] c);
    return (c >= ASCII_LC_A) && (c <= ASCII_LC_Z);
  endfunction

endpackage

// File: rtl/ascii_case_fold_v.sv
// ascii_case_fold_v
//   Combinational 8-bit ASCII case folder. It maps 'a'..'z' to 'A'..'Z'.
//   All other codes pass through unchanged.
//   Ports:
//     ch      in   8  character to fold
//     folded  out  8  folded character
module ascii_case_fold_v
  import ascii_word_packer_v_pkg::*;
(
  input  logic [7:0] ch,
  output logic [7:0] folded
);

  assign folded = is_lower(ch) ? (ch - ASCII_CASE_OFS) : ch;

endmodule

// File: rtl/ascii_word_packer_v.sv
// ascii_word_packer_v
//   Packs a valid/ready stream of CHAR_W-bit characters into CHARS-character
//   words. The first character received lands in the most significant
//   position. A word cut short by i_last is right-aligned and zero-filled in
//   its upper characters. The output word is registered and held under
//   backpressure. One completed word can wait in the assembly register while
//   the output slot is occupied.
//
//   Optional feature: define PACKER_UPCASE_EN to fold 'a'..'z' to upper case
//   before packing. The fold applies only when CHAR_W == 8.
//
//   Handshakes. Input and output use the same valid/ready rule. A transfer
//   happens on the rising edge where valid and ready are both high. The
//   producer holds its data stable while valid is high and ready is low.
//   Input side: i_valid / o_in_ready. Output side: o_valid / i_out_ready.
//
//   Ports:
//     clk          in   1              rising-edge clock
//     rst_n        in   1              asynchronous active-low reset
//     i_char       in   CHAR_W         incoming character
//     i_valid      in   1              i_char / i_last valid
//     i_last       in   1              this character ends the word early
//     o_in_ready   out  1              packer accepts a character this cycle
//     o_code       out  CHARS*CHAR_W   packed word
//     o_len        out  LEN_W          real characters in o_code (1..CHARS)
//     o_valid      out  1              o_code / o_len valid
//     i_out_ready  in   1              downstream consumes the word this cycle
//     dbg_state    out  enum           current FSM state (observation only)
module ascii_word_packer_v
  import ascii_word_packer_v_pkg::*;
#(
  parameter  int CHARS  = CHARS_DEF,
  parameter  int CHAR_W = CHAR_W_DEF,
  localparam int WORD_W = CHARS * CHAR_W,
  localparam int LEN_W  = $clog2(CHARS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHAR_W-1:0]   i_char,
  input  logic                i_valid,
  input  logic                i_last,
  output logic                o_in_ready,
  output logic [WORD_W-1:0]   o_code,
  output logic [LEN_W-1:0]    o_len,
  output logic                o_valid,
  input  logic                i_out_ready,
  output packer_state_e       dbg_state
);

  packer_state_e     state;
  logic [WORD_W-1:0] asm_q;   // assembly register; holds the pending word in ST_PEND
  logic [LEN_W-1:0]  cnt;     // characters in asm_q; holds the full length in ST_PEND

  logic [CHAR_W-1:0] pack_char;
  logic [WORD_W-1:0] asm_next;
  logic [LEN_W-1:0]  cnt_next;
  logic              accept;
  logic              word_done;
  logic              slot_free;

  // Character conditioning ahead of the shift register.
`ifdef PACKER_UPCASE_EN
  generate
    if (CHAR_W == 8) begin : g_fold
      ascii_case_fold_v u_fold (
        .ch     (i_char),
        .folded (pack_char)
      );
    end else begin : g_pass
      assign pack_char = i_char;
    end
  endgenerate
`else
  assign pack_char = i_char;
`endif

  assign o_in_ready = (state == ST_ACC);
  assign dbg_state  = state;

  assign accept    = i_valid && o_in_ready;
  assign asm_next  = {asm_q[(CHARS-1)*CHAR_W-1:0], pack_char};
  assign cnt_next  = cnt + LEN_W'(1);
  // A word is complete when it fills up or when i_last ends it early.
  assign word_done = (cnt == LEN_W'(CHARS - 1)) || i_last;
  // The slot can take a new word if it is empty or drains on this edge.
  assign slot_free = !o_valid || i_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ACC;
      asm_q   <= '0;
      cnt     <= '0;
      o_code  <= '0;
      o_len   <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          // Release the slot on a drain. A word loaded on the same edge
          // overrides this below, so o_valid stays high.
          if (i_out_ready) o_valid <= 1'b0;
          if (accept) begin
            if (word_done && slot_free) begin
              o_code  <= asm_next;
              o_len   <= cnt_next;
              o_valid <= 1'b1;
              asm_q   <= '0;
              cnt     <= '0;
            end else if (word_done) begin
              // The slot is busy. Park the finished word, then stop input.
              asm_q <= asm_next;
              cnt   <= cnt_next;
              state <= ST_PEND;
            end else begin
              asm_q <= asm_next;
              cnt   <= cnt_next;
            end
          end
        end
        ST_PEND: begin
          // The slot is always full here. Replace the word when it drains.
          if (i_out_ready) begin
            o_code  <= asm_q;
            o_len   <= cnt;
            o_valid <= 1'b1;
            asm_q   <= '0;
            cnt     <= '0;
            state   <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule
